mux_scan_sequencer: RTL

//  Drives the select pair (s1,s2) of the mux4to1 gate-level multiplexer through channels 0..3
//  and samples its Y output once per channel. Packs the four results into a 4-bit word with a
//  one-cycle valid strobe. Sits directly around mux4to1: its select driver upstream and its

---
 rtl/mux_scan_sequencer_if.sv | 40 ++++
 rtl/mux_scan_sequencer.sv | 110 +++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if
//   Groups the handshake and mux-facing signals of mux_scan_sequencer.
//   master : the environment side (drives start, returns the mux Y output)
//   slave  : the sequencer side
// Signals
//   start      request level toward the sequencer
//   y_in       Y output of the mux4to1 being scanned
//   s1, s2     mux select MSB / LSB
//   busy       scan in progress
//   data_out   packed scan result, bit k = Y while channel k was selected
//   data_valid one-cycle strobe marking a fresh data_out
interface mux_scan_sequencer_if;
  logic       start;
  logic       y_in;
  logic       s1;
  logic       s2;
  logic       busy;
  logic [3:0] data_out;
  logic       data_valid;

  modport master (
    output start,
    output y_in,
    input  s1,
    input  s2,
    input  busy,
    input  data_out,
    input  data_valid
  );

  modport slave (
    input  start,
    input  y_in,
    output s1,
    output s2,
    output busy,
    output data_out,
    output data_valid
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Walks the select pair of a mux4to1 through channels 0..3, holds each select for
//   SETTLE cycles, samples Y at the end of each hold and publishes the four samples as
//   one word with a single-cycle valid strobe.
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   scan  slave modport of mux_scan_sequencer_if (start, y_in in; s1, s2, busy,
//         data_out, data_valid out, all outputs registered)
// Parameters
//   SETTLE  cycles each select is held before Y is sampled (1..15)
//   B2B_EN  start seen at the final-sample edge chains straight into the next scan
//
// state | meaning
// IDLE  | selects parked at channel 0, waiting for start
// SCAN  | stepping through channels, settle timer running
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1,
  parameter bit          B2B_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  mux_scan_sequencer_if.slave scan
);

  typedef enum logic {IDLE, SCAN} state_t;

  // Settle timer counts down from SETTLE-1; zero is the sample edge.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [1:0] chan_q, chan_d;
  logic [2:0] shadow_q, shadow_d;
  logic [3:0] dout_q, dout_d;
  logic       dv_q, dv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      chan_q   <= 2'd0;
      shadow_q <= 3'd0;
      dout_q   <= 4'd0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      chan_q   <= chan_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    chan_d   = chan_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    dv_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (scan.start) begin
          state_d  = SCAN;
          chan_d   = 2'd0;
          settle_d = SETTLE_LAST;
          shadow_d = 3'd0;
        end
      end

      SCAN: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          settle_d = SETTLE_LAST;
          unique case (chan_q)
            2'd0: shadow_d[0] = scan.y_in;
            2'd1: shadow_d[1] = scan.y_in;
            2'd2: shadow_d[2] = scan.y_in;
            2'd3: begin
              // Channel 3 goes straight into the result, never via the shadow.
              dout_d = {scan.y_in, shadow_q};
              dv_d   = 1'b1;
              if (B2B_EN && scan.start) begin
                shadow_d = 3'd0;
              end else begin
                state_d  = IDLE;
                settle_d = 4'd0;
              end
            end
            default: ;
          endcase
          chan_d = chan_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign scan.s1         = chan_q[1];
  assign scan.s2         = chan_q[0];
  assign scan.busy       = (state_q == SCAN);
  assign scan.data_out   = dout_q;
  assign scan.data_valid = dv_q;

endmodule
